// File: rtl/alu_exec_stage.sv
// alu_exec_stage: one-at-a-time execute stage wrapping the add/sub/mul/div/compare units
// behind valid/ready handshakes, holding a two-word result until it is consumed.
module alu_exec_stage #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_lo,
   output logic [WIDTH-1:0] out_hi,
   output logic             out_dz,
   output logic             out_bad_op,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
   state_t             r_state, w_next;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_lo, r_hi;
   logic               r_dz, r_bad;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   w_sum, w_diff, w_q, w_r, w_lo, w_hi;
   logic               w_carry, w_borrow, w_lt, w_gt, w_eq, w_bz, w_dz, w_bad;
   logic [2*WIDTH-1:0] w_prod;
   // arithmetic units, fed only from the latched operands
   assign {w_carry, w_sum}   = {1'b0, r_a} + {1'b0, r_b};
   assign {w_borrow, w_diff} = {1'b0, r_a} - {1'b0, r_b};
   assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
   assign w_bz   = (r_b == '0);
   assign w_q    = w_bz ? '1 : r_a / r_b;
   assign w_r    = w_bz ? r_a : r_a % r_b;
   assign w_lt   = r_a < r_b;
   assign w_gt   = r_a > r_b;
   assign w_eq   = r_a == r_b;
   always_comb begin
      w_lo  = '0;
      w_hi  = '0;
      w_dz  = 1'b0;
      w_bad = 1'b0;
      case (r_op)
         3'd0: begin w_lo = w_sum; w_hi = WIDTH'(w_carry); end
         3'd1: begin w_lo = w_diff; w_hi = WIDTH'(w_borrow); end
         3'd2: begin w_lo = w_prod[WIDTH-1:0]; w_hi = w_prod[2*WIDTH-1:WIDTH]; end
         3'd3: begin w_lo = w_q; w_hi = w_r; w_dz = w_bz; end
         3'd4: w_lo = WIDTH'(w_lt);
         3'd5: w_lo = WIDTH'(w_gt);
         3'd6: w_lo = WIDTH'(w_eq);
         default: w_bad = 1'b1;
      endcase
   end
   always_comb begin
      w_next = (r_state == S_IDLE) ? (in_valid ? S_EXEC : S_IDLE) :
               (r_state == S_EXEC) ? S_DONE :
               (r_state == S_DONE && !out_ready) ? S_DONE : S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_dz    <= 1'b0;
         r_bad   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && in_valid) begin
            r_op <= in_op;
            r_a  <= in_a;
            r_b  <= in_b;
         end
         if (r_state == S_EXEC) begin
            r_lo  <= w_lo;
            r_hi  <= w_hi;
            r_dz  <= w_dz;
            r_bad <= w_bad;
         end
         if (r_state == S_DONE && out_ready) r_cnt <= r_cnt + CNT_W'(1);
      end
   end
   assign in_ready   = (r_state == S_IDLE) & ~rst;
   assign out_valid  = (r_state == S_DONE);
   assign out_lo     = r_lo;
   assign out_hi     = r_hi;
   assign out_dz     = r_dz;
   assign out_bad_op = r_bad;
   assign op_count   = r_cnt;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table plus backpressure, reset and counter-wrap sequences.
module tb_alu_exec_stage;
   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, out_dz, out_bad_op, in_ready, out_valid;
   logic [2:0] in_op;
   logic [3:0] in_a, in_b, out_lo, out_hi;
   logic [7:0] op_count, exp_cnt;
   int         checks = 0, errors = 0;
   typedef struct {
      logic [2:0] op;
      logic [3:0] a, b, lo, hi;
      logic       dz, bad;
   } vec_t;
   vec_t vt[18];
   alu_exec_stage #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_lo(out_lo), .out_hi(out_hi), .out_dz(out_dz), .out_bad_op(out_bad_op),
      .op_count(op_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_clear(input string n);
      chk({n, " out_valid"}, out_valid, 0);
      chk({n, " out_lo"}, out_lo, 0);
      chk({n, " out_hi"}, out_hi, 0);
      chk({n, " out_dz"}, out_dz, 0);
      chk({n, " out_bad_op"}, out_bad_op, 0);
      chk({n, " op_count"}, op_count, 0);
   endtask
   task automatic run(input vec_t v, input string n);
      chk({n, " in_ready idle"}, in_ready, 1);
      in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b;
      step();
      in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b;
      chk({n, " exec in_ready"}, in_ready, 0);
      chk({n, " exec out_valid"}, out_valid, 0);
      step();
      chk({n, " out_valid"}, out_valid, 1);
      chk({n, " out_lo"}, out_lo, v.lo);
      chk({n, " out_hi"}, out_hi, v.hi);
      chk({n, " out_dz"}, out_dz, v.dz);
      chk({n, " out_bad_op"}, out_bad_op, v.bad);
      step();
      exp_cnt++;
      chk({n, " op_count"}, op_count, exp_cnt);
      chk({n, " in_ready after"}, in_ready, 1);
      chk({n, " out_valid after"}, out_valid, 0);
   endtask
   task automatic reset_dut();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      exp_cnt = 8'd0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      vec_t v;
      logic [4:0] s;
      vt[0]  = '{3'd0, 4'd9,  4'd8,  4'd1,  4'd1,  1'b0, 1'b0};
      vt[1]  = '{3'd1, 4'd3,  4'd5,  4'd14, 4'd1,  1'b0, 1'b0};
      vt[2]  = '{3'd2, 4'd15, 4'd15, 4'd1,  4'd14, 1'b0, 1'b0};
      vt[3]  = '{3'd3, 4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 1'b0};
      vt[4]  = '{3'd3, 4'd7,  4'd0,  4'd15, 4'd7,  1'b1, 1'b0};
      vt[5]  = '{3'd4, 4'd2,  4'd9,  4'd1,  4'd0,  1'b0, 1'b0};
      vt[6]  = '{3'd5, 4'd2,  4'd9,  4'd0,  4'd0,  1'b0, 1'b0};
      vt[7]  = '{3'd6, 4'd6,  4'd6,  4'd1,  4'd0,  1'b0, 1'b0};
      vt[8]  = '{3'd7, 4'd5,  4'd3,  4'd0,  4'd0,  1'b0, 1'b1};
      vt[9]  = '{3'd6, 4'd6,  4'd7,  4'd0,  4'd0,  1'b0, 1'b0};
      vt[10] = '{3'd0, 4'd15, 4'd1,  4'd0,  4'd1,  1'b0, 1'b0};
      vt[11] = '{3'd1, 4'd5,  4'd5,  4'd0,  4'd0,  1'b0, 1'b0};
      vt[12] = '{3'd2, 4'd3,  4'd5,  4'd15, 4'd0,  1'b0, 1'b0};
      vt[13] = '{3'd3, 4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 1'b0};
      vt[14] = '{3'd3, 4'd0,  4'd0,  4'd15, 4'd0,  1'b1, 1'b0};
      vt[15] = '{3'd4, 4'd9,  4'd2,  4'd0,  4'd0,  1'b0, 1'b0};
      vt[16] = '{3'd5, 4'd9,  4'd2,  4'd1,  4'd0,  1'b0, 1'b0};
      vt[17] = '{3'd1, 4'd0,  4'd1,  4'd15, 4'd1,  1'b0, 1'b0};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = 3'd0; in_a = 4'd0; in_b = 4'd0;
      exp_cnt = 8'd0;
      step();
      step();
      chk_clear("reset");
      chk("reset in_ready", in_ready, 0);
      rst = 1'b0;
      step();
      for (int i = 0; i < 18; i++) run(vt[i], $sformatf("vec%0d", i));
      // backpressure: result held while a competing request is presented
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'd0; in_a = 4'd9; in_b = 4'd8;
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1; in_op = 3'd2; in_a = 4'd15; in_b = 4'd15;
      for (int k = 0; k < 5; k++) begin
         chk("bp out_valid", out_valid, 1);
         chk("bp out_lo", out_lo, 1);
         chk("bp out_hi", out_hi, 1);
         chk("bp in_ready", in_ready, 0);
         chk("bp op_count", op_count, exp_cnt);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      exp_cnt++;
      chk("bp release op_count", op_count, exp_cnt);
      chk("bp release in_ready", in_ready, 1);
      chk("bp release out_valid", out_valid, 0);
      step();
      chk("bp not accepted", out_valid, 0);
      chk("bp still idle", in_ready, 1);
      // reset during EXEC
      in_valid = 1'b1; in_op = 3'd0; in_a = 4'd9; in_b = 4'd8;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      chk_clear("rst exec");
      chk("rst exec in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst exec in_ready low", in_ready, 1);
      step();
      chk("rst exec idle", out_valid, 0);
      // reset during DONE
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'd2; in_a = 4'd15; in_b = 4'd15;
      step();
      in_valid = 1'b0;
      step();
      chk("rst done pre valid", out_valid, 1);
      rst = 1'b1;
      step();
      chk_clear("rst done");
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst done in_ready", in_ready, 1);
      step();
      exp_cnt = 8'd0;
      v = '{3'd0, 4'd1, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0};
      run(v, "post rst add");
      // counter wrap over 256 back-to-back operations
      reset_dut();
      in_valid = 1'b1; in_op = 3'd0;
      for (int i = 0; i < 256; i++) begin
         in_a = i[3:0]; in_b = i[7:4];
         s = {1'b0, in_a} + {1'b0, in_b};
         chk("wrap in_ready", in_ready, 1);
         step();
         chk("wrap exec", out_valid, 0);
         step();
         chk("wrap out_valid", out_valid, 1);
         chk("wrap out_lo", out_lo, s[3:0]);
         chk("wrap out_hi", out_hi, s[4]);
         step();
         exp_cnt++;
         chk("wrap op_count", op_count, exp_cnt);
      end
      in_valid = 1'b0;
      chk("wrap final count", op_count, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
